// File: rtl/dp1m4_pkg.sv
// dp1m4_pkg: shared constants, types and mask helper for the 2:4 sparse dot-product row
package dp1m4_pkg;
  localparam int grp = 4;
  localparam int idx_w = 2;
  localparam int psum_w = 20;
  typedef logic [psum_w-1:0] psum_t;
  typedef logic [grp-1:0] nib_t;
  function automatic int cnt_below(input nib_t m, input logic [idx_w-1:0] idx);
    int n;
    n = 0;
    for (int i = 0; i < grp; i++) if (i < int'(idx) && m[i]) n++;
    return n;
  endfunction
endpackage

// File: rtl/dp1m4_pe.sv
// dp1m4_pe: one column -- compressed weight select, multiply, wrapping accumulator
module dp1m4_pe
  import dp1m4_pkg::*;
#(
  parameter int bw = 4,
  parameter int psum_bw = 20,
  parameter int ncol = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [bw-1:0]        w [ncol],
  input  nib_t                 mask,
  input  logic [bw-1:0]        activation,
  input  logic [idx_w-1:0]     activation_index,
  input  logic                 load,
  input  logic                 execute,
  input  logic [psum_bw-1:0]   psum_in,
  output logic [psum_bw-1:0]   acc
);
  logic [bw-1:0] sel_w;
  logic [2*bw-1:0] prod;
  logic [psum_bw-1:0] add, acc_d, acc_q;
  int k;
  always_comb begin
    k = cnt_below(mask, activation_index);
    sel_w = '0;
    for (int i = 0; i < ncol; i++) if (mask[activation_index] && k == i) sel_w = w[i];
    prod = {{bw{1'b0}}, activation} * {{bw{1'b0}}, sel_w};
    add = execute ? psum_bw'(prod) : '0;
    acc_d = load ? psum_in + add : acc_q + add;
  end
  always_ff @(posedge clk) acc_q <= reset ? '0 : acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/dp1m4_row.sv
// dp1m4_row: row of col PEs sharing one streamed activation, 2:4 compressed weights
module dp1m4_row
  import dp1m4_pkg::*;
#(
  parameter int col = 4,
  parameter int bw = 4,
  parameter int psum_bw = 20,
  parameter int ncol = 2,
  parameter int nnz = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          weights [nnz],
  input  logic [grp*col-1:0]     weight_mask,
  input  logic [bw-1:0]          activation,
  input  logic [idx_w-1:0]       activation_index,
  input  logic                   load,
  input  logic                   execute,
  input  logic [psum_bw-1:0]     psum_in [col],
  output logic                   load_out,
  output logic [psum_bw-1:0]     psum_out [col]
);
  logic load_out_d, load_out_q;
  always_comb load_out_d = load;
  always_ff @(posedge clk) load_out_q <= reset ? 1'b0 : load_out_d;
  assign load_out = load_out_q;
  for (genvar c = 0; c < col; c++) begin : g_pe
    logic [bw-1:0] w_c [ncol];
    always_comb for (int i = 0; i < ncol; i++) w_c[i] = weights[c*ncol+i];
    dp1m4_pe #(.bw(bw), .psum_bw(psum_bw), .ncol(ncol)) u_pe (
      .clk(clk),
      .reset(reset),
      .w(w_c),
      .mask(weight_mask[grp*c +: grp]),
      .activation(activation),
      .activation_index(activation_index),
      .load(load),
      .execute(execute),
      .psum_in(psum_in[c]),
      .acc(psum_out[c])
    );
  end
endmodule

// File: tb/tb_dp1m4_row.sv
// tb_dp1m4_row: directed vectors with a queue scoreboard checked by a negedge monitor
module tb_dp1m4_row;
  import dp1m4_pkg::*;
  typedef logic [3:0][19:0] pv_t;
  typedef struct packed {
    logic [7:0] id;
    pv_t p;
    logic lo;
  } exp_t;
  logic clk = 0, reset = 1, load = 0, execute = 0, load_out;
  logic [3:0] weights [8];
  logic [15:0] weight_mask = '0;
  logic [3:0] activation = '0;
  logic [1:0] activation_index = '0;
  logic [19:0] psum_in [4], psum_out [4];
  exp_t q[$];
  exp_t e;
  int n_vec = 0, n_bad = 0;
  logic [7:0] vid = 0;
  localparam logic [19:0] mx = 20'hFFFFF;
  localparam logic [15:0] mk_spec = 16'b0110_1001_0110_1010;

  dp1m4_row dut (
    .clk(clk), .reset(reset), .weights(weights), .weight_mask(weight_mask),
    .activation(activation), .activation_index(activation_index),
    .load(load), .execute(execute), .psum_in(psum_in),
    .load_out(load_out), .psum_out(psum_out)
  );

  always #5 clk = ~clk;

  function automatic pv_t pv(input logic [19:0] a, b, c, d);
    pv_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic step(input logic rst, ld, ex, input logic [3:0] act, input logic [1:0] idx,
                      input logic [15:0] msk, input pv_t pin, input pv_t ep, input logic elo);
    @(negedge clk);
    reset = rst; load = ld; execute = ex; activation = act;
    activation_index = idx; weight_mask = msk;
    for (int c = 0; c < 4; c++) psum_in[c] = pin[c];
    @(posedge clk);
    #1;
    vid++;
    q.push_back('{id: vid, p: ep, lo: elo});
  endtask

  always @(negedge clk) if (q.size() > 0) begin
    e = q.pop_front();
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (psum_out[c] !== e.p[c]) begin
        n_bad++;
        $display("FAIL vec%0d psum_out[%0d] got %0d expected %0d", e.id, c, psum_out[c], e.p[c]);
      end
    end
    n_vec++;
    if (load_out !== e.lo) begin
      n_bad++;
      $display("FAIL vec%0d load_out got %b expected %b", e.id, load_out, e.lo);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    pv_t z;
    z = '0;
    for (int i = 0; i < 8; i++) weights[i] = 4'(i);
    for (int c = 0; c < 4; c++) psum_in[c] = '0;
    step(1, 0, 0, 0, 0, 0, z, z, 0);
    step(1, 1, 1, 9, 0, 16'hFFFF, z, z, 0);
    step(0, 1, 1, 3, 1, mk_spec, pv(0, 1, 2, 3), pv(0, 7, 2, 21), 1);
    step(0, 0, 1, 2, 2, mk_spec, z, pv(0, 13, 2, 35), 0);
    step(0, 0, 1, 2, 2, mk_spec, z, pv(0, 19, 2, 49), 0);
    step(0, 0, 1, 2, 2, mk_spec, z, pv(0, 25, 2, 63), 0);
    step(0, 0, 1, 2, 2, mk_spec, z, pv(0, 31, 2, 77), 0);
    step(0, 0, 1, 1, 3, mk_spec, z, pv(1, 31, 7, 77), 0);
    step(0, 0, 1, 1, 3, mk_spec, z, pv(2, 31, 12, 77), 0);
    step(0, 0, 1, 1, 3, mk_spec, z, pv(3, 31, 17, 77), 0);
    step(0, 0, 1, 1, 3, mk_spec, z, pv(4, 31, 22, 77), 0);
    step(0, 0, 0, 3, 1, mk_spec, z, pv(4, 31, 22, 77), 0);
    step(0, 1, 0, 3, 1, mk_spec, pv(10, 20, 30, 40), pv(10, 20, 30, 40), 1);
    step(0, 0, 1, 5, 2, 16'hFFFF, z, pv(10, 20, 30, 40), 0);
    step(0, 0, 1, 5, 3, 16'hFFFF, z, pv(10, 20, 30, 40), 0);
    step(0, 0, 1, 5, 1, 16'hFFFF, z, pv(15, 35, 55, 75), 0);
    step(0, 0, 1, 2, 0, 16'hFFFF, z, pv(15, 39, 63, 87), 0);
    step(0, 1, 0, 7, 1, 16'hFFFF, pv(mx, mx, mx, mx), pv(mx, mx, mx, mx), 1);
    step(0, 0, 1, 1, 1, 16'hFFFF, z, pv(0, 2, 4, 6), 0);
    step(0, 1, 1, 3, 0, 16'hFFFF, pv(mx, mx, mx, mx), pv(mx, 5, 11, 17), 1);
    step(0, 0, 1, 3, 1, 16'hFFFF, z, pv(2, 14, 26, 38), 0);
    step(1, 1, 1, 3, 1, 16'hFFFF, pv(9, 9, 9, 9), z, 0);
    step(0, 0, 1, 1, 1, 16'hFFFF, z, pv(1, 3, 5, 7), 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dp1m4_row.md
DP1M4_ROW -- requirements
Module: dp1m4_row

Interface
REQ-001 Parameter col, default 4: number of output columns (PEs) in the row.
REQ-002 Parameter bw, default 4: activation and weight width, unsigned.
REQ-003 Parameter psum_bw, default 20: partial-sum width.
REQ-004 Parameter ncol, default 2: stored nonzero weights per column per group of 4 (2:4 sparsity).
REQ-005 Parameter nnz, default 8: total stored weights, SHALL equal col*ncol.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 weights  input  unpacked [nnz] x bw  compressed weights; column c owns entries c*ncol .. c*ncol+ncol-1.
REQ-009 weight_mask  input  4*col  bits [4c+3:4c] = column c occupancy of positions 0..3 of the 4-element group.
REQ-010 activation  input  bw  streamed activation value.
REQ-011 activation_index  input  2  position (0..3) of activation within its group.
REQ-012 load  input  1  capture psum_in into the accumulators.
REQ-013 execute  input  1  accumulate the current activation's products.
REQ-014 psum_in  input  unpacked [col] x psum_bw  incoming partial sums.
REQ-015 load_out  output  1  load delayed one cycle, for the next row.
REQ-016 psum_out  output  unpacked [col] x psum_bw  accumulator contents, driven directly from registers.

Function
REQ-017 Weight select per column c: k = count of set bits in mask nibble c strictly below activation_index; if mask bit [4c+activation_index] is set and k < ncol, selected weight = weights[c*ncol+k]; otherwise product = 0.
REQ-018 Product = activation x selected weight, unsigned, 2*bw bits, zero-extended to psum_bw.
REQ-019 Accumulator arithmetic SHALL wrap modulo 2^psum_bw; no saturation.
REQ-020 load=1: acc[c] <= psum_in[c] + (execute ? product[c] : 0); load takes priority over plain accumulation.
REQ-021 load=0, execute=1: acc[c] <= acc[c] + product[c].
REQ-022 load=0, execute=0: acc[c] holds.
REQ-023 load_out <= load each cycle; latency exactly 1 cycle.
REQ-024 weights and weight_mask are used combinationally each cycle (no internal weight storage); changing them takes effect on the next edge.
REQ-025 Nibbles with more than ncol set bits: set positions beyond the ncol-th contribute 0.
REQ-026 All columns update in parallel in the same cycle; no handshake or backpressure.

Reset
REQ-027 reset=1 at a rising edge: all acc[c] <= 0 and load_out <= 0, overriding load/execute.
REQ-028 Reset asserted mid-accumulation SHALL discard all partial sums within one cycle.

Structure
REQ-029 Shared package holds the group size (4), activation_index width (2) and a psum vector typedef.
REQ-030 One sub-module dp1m4_pe (one column: weight select, multiplier, accumulator), instantiated col times via generate.

Verification
REQ-031 Reset: hold reset 1 for 2 edges -> psum_out all 0, load_out 0.
REQ-032 Use weights[i]=i and weight_mask=16'b0110_1001_0110_1010 for REQ-033..035.
REQ-033 Load: psum_in={0,1,2,3}, load=1, execute=1, activation=3, index=1, one edge -> psum_out={0,7,2,21}, load_out=1 the next cycle.
REQ-034 Execute: activation=2, index=2, 4 edges -> psum_out={0,31,2,77}, load_out=0.
REQ-035 Execute: activation=1, index=3, 4 edges -> psum_out={4,31,22,77}.
REQ-036 Hold and wrap: execute=0 -> psum_out unchanged; with acc preloaded to 2^20-1, one product of 1 -> acc=0; reset asserted mid-run -> all 0 next edge.
